// File: rtl/uart_tx_arb_pkg.sv
// Shared types and message-length constants for the UART TX arbiter.
// UART_TX_ARB_CHECKSUM_EN adds one trailing XOR checksum byte to every message.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  localparam logic SRC_RF  = 1'b0;
  localparam logic SRC_ALU = 1'b1;

`ifdef UART_TX_ARB_CHECKSUM_EN
  localparam int RF_LEN  = 2;
  localparam int ALU_LEN = 3;
`else
  localparam int RF_LEN  = 1;
  localparam int ALU_LEN = 2;
`endif

  // Width of the "bytes still to send" counter; covers ALU_LEN-1.
  localparam int LEFT_W = 2;

endpackage

// File: rtl/uart_tx_arb_slot.sv
// One-deep holding register for a single message source, with overflow detect.
// A pulse is accepted when the slot is empty or is being granted in the same cycle.
module uart_tx_arb_slot
  import uart_tx_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_vld,
  input  logic [W-1:0] load_data,
  input  logic         grant,
  output logic         full,
  output logic         full_nxt,
  output logic [W-1:0] data,
  output logic         ovf_evt
);

  logic accept;

  always_comb begin
    accept   = load_vld && (!full || grant);
    full_nxt = accept || (full && !grant);
    ovf_evt  = load_vld && !accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full <= 1'b0;
    else        full <= full_nxt;
  end

  always_ff @(posedge clk) begin
    if (accept) data <= load_data;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding RF bytes and split ALU results to the UART TX level handshake.
// Optional UART_TX_ARB_CHECKSUM_EN appends an XOR checksum byte to each message.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WAIT_MAX   = 255,
  parameter int CNT_W      = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    UART_TX_Busy,
  input  logic                    ERR_CLR,
  output logic [DATA_WIDTH-1:0]   UART_TX_DATA,
  output logic                    UART_TX_VLD,
  output logic                    ARB_IDLE,
  output logic                    RF_OVF,
  output logic                    ALU_OVF,
  output logic                    TX_TIMEOUT
);

  logic                    rf_full, rf_full_nxt, rf_ovf_evt, rf_grant;
  logic                    alu_full, alu_full_nxt, alu_ovf_evt, alu_grant;
  logic [DATA_WIDTH-1:0]   rf_data;
  logic [2*DATA_WIDTH-1:0] alu_data;
  arb_state_t              state;
  logic                    last_grant;
  logic [CNT_W-1:0]        cnt;
  logic [LEFT_W-1:0]       bytes_left;
  logic                    go_idle, timeout_evt, advance;
  logic [DATA_WIDTH-1:0]   tx_sr [ALU_LEN-1];

  uart_tx_arb_slot #(.W(DATA_WIDTH)) u_rf_slot (
    .clk(CLK), .rst_n(RST), .load_vld(RF_RdData_VLD), .load_data(RF_RdData),
    .grant(rf_grant), .full(rf_full), .full_nxt(rf_full_nxt), .data(rf_data),
    .ovf_evt(rf_ovf_evt)
  );

  uart_tx_arb_slot #(.W(2*DATA_WIDTH)) u_alu_slot (
    .clk(CLK), .rst_n(RST), .load_vld(ALU_OUT_VLD), .load_data(ALU_OUT),
    .grant(alu_grant), .full(alu_full), .full_nxt(alu_full_nxt), .data(alu_data),
    .ovf_evt(alu_ovf_evt)
  );

  always_comb begin
    rf_grant  = 1'b0;
    alu_grant = 1'b0;
    if (state == ST_IDLE && !UART_TX_Busy) begin
      if (rf_full && alu_full) begin
        rf_grant  = (last_grant == SRC_ALU);
        alu_grant = (last_grant == SRC_RF);
      end else begin
        rf_grant  = rf_full;
        alu_grant = alu_full;
      end
    end
    advance     = (state == ST_DRAIN) && !UART_TX_Busy && (bytes_left != '0);
    go_idle     = (state == ST_IDLE && !rf_grant && !alu_grant) ||
                  (state == ST_DRAIN && !UART_TX_Busy && bytes_left == '0);
    timeout_evt = (state == ST_REQ) && !UART_TX_Busy && (cnt == CNT_W'(WAIT_MAX - 1));
  end

  // Remaining bytes of the granted message; head byte goes straight to UART_TX_DATA.
  always_ff @(posedge CLK) begin
    if (alu_grant) begin
      tx_sr[0] <= alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef UART_TX_ARB_CHECKSUM_EN
      tx_sr[1] <= alu_data[DATA_WIDTH-1:0] ^ alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
`endif
    end
`ifdef UART_TX_ARB_CHECKSUM_EN
    else if (rf_grant) tx_sr[0] <= rf_data;
`endif
    else if (advance) begin
      for (int i = 0; i < ALU_LEN - 2; i++) tx_sr[i] <= tx_sr[i+1];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= ST_IDLE;
      last_grant   <= SRC_ALU;
      cnt          <= '0;
      bytes_left   <= '0;
      UART_TX_VLD  <= 1'b0;
      UART_TX_DATA <= '0;
      ARB_IDLE     <= 1'b1;
      RF_OVF       <= 1'b0;
      ALU_OVF      <= 1'b0;
      TX_TIMEOUT   <= 1'b0;
    end else begin
      // Error events take priority over ERR_CLR in the same cycle.
      RF_OVF     <= rf_ovf_evt  || (RF_OVF     && !ERR_CLR);
      ALU_OVF    <= alu_ovf_evt || (ALU_OVF    && !ERR_CLR);
      TX_TIMEOUT <= timeout_evt || (TX_TIMEOUT && !ERR_CLR);
      ARB_IDLE   <= go_idle && !rf_full_nxt && !alu_full_nxt;
      case (state)
        ST_IDLE: begin
          if (rf_grant) begin
            state        <= ST_REQ;
            UART_TX_VLD  <= 1'b1;
            UART_TX_DATA <= rf_data;
            last_grant   <= SRC_RF;
            bytes_left   <= LEFT_W'(RF_LEN - 1);
            cnt          <= '0;
          end else if (alu_grant) begin
            state        <= ST_REQ;
            UART_TX_VLD  <= 1'b1;
            UART_TX_DATA <= alu_data[DATA_WIDTH-1:0];
            last_grant   <= SRC_ALU;
            bytes_left   <= LEFT_W'(ALU_LEN - 1);
            cnt          <= '0;
          end
        end
        ST_REQ: begin
          if (UART_TX_Busy) begin
            state       <= ST_DRAIN;
            UART_TX_VLD <= 1'b0;
            cnt         <= '0;
          end else if (cnt != CNT_W'(WAIT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (advance) begin
            state        <= ST_REQ;
            UART_TX_VLD  <= 1'b1;
            UART_TX_DATA <= tx_sr[0];
            bytes_left   <= bytes_left - LEFT_W'(1);
          end else if (!UART_TX_Busy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized messages
// against a message-level reference model and a reactive TX busy model.
module tb_uart_tx_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RF_RdData;
  logic        RF_RdData_VLD;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        UART_TX_Busy;
  logic        ERR_CLR;
  logic [7:0]  UART_TX_DATA;
  logic        UART_TX_VLD;
  logic        ARB_IDLE, RF_OVF, ALU_OVF, TX_TIMEOUT;

  always #5 CLK = ~CLK;

  uart_tx_arbiter dut (
    .CLK(CLK), .RST(RST), .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .UART_TX_Busy(UART_TX_Busy),
    .ERR_CLR(ERR_CLR), .UART_TX_DATA(UART_TX_DATA), .UART_TX_VLD(UART_TX_VLD),
    .ARB_IDLE(ARB_IDLE), .RF_OVF(RF_OVF), .ALU_OVF(ALU_OVF), .TX_TIMEOUT(TX_TIMEOUT)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       last_src;
  int         busy_auto;
  int         dly_lo, dly_hi, hold_lo, hold_hi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: byte sequence of each message and round-robin order.
  task automatic push_rf(input logic [7:0] d);
    exp_q.push_back(d);
`ifdef UART_TX_ARB_CHECKSUM_EN
    exp_q.push_back(d);
`endif
    last_src = 1'b0;
  endtask

  task automatic push_alu(input logic [15:0] v);
    logic [7:0] lo, hi;
    lo = v[7:0];
    hi = v[15:8];
    exp_q.push_back(lo);
    exp_q.push_back(hi);
`ifdef UART_TX_ARB_CHECKSUM_EN
    exp_q.push_back(lo ^ hi);
`endif
    last_src = 1'b1;
  endtask

  task automatic push_both(input logic [7:0] d, input logic [15:0] v);
    if (last_src) begin push_rf(d); push_alu(v); end
    else          begin push_alu(v); push_rf(d); end
  endtask

  // TX side: raise busy a few cycles after VLD, capture the byte, hold busy a while.
  initial begin
    int w, hold_left, dly, hold;
    logic rose, prev_vld;
    logic [7:0] prev_data;
    UART_TX_Busy = 1'b0;
    w = 0; hold_left = 0; dly = 1; hold = 1; rose = 1'b0; prev_vld = 1'b0; prev_data = '0;
    forever begin
      @(posedge CLK); #2;
      if (rose) begin chk("vld_drop_after_busy", UART_TX_VLD, 0); rose = 1'b0; end
      if (prev_vld && UART_TX_VLD) chk("data_stable", UART_TX_DATA, prev_data);
      prev_vld  = UART_TX_VLD;
      prev_data = UART_TX_DATA;
      if (busy_auto == 0) begin
        UART_TX_Busy = 1'b0;
        w = 0;
      end else if (UART_TX_Busy) begin
        hold_left--;
        if (hold_left <= 0) UART_TX_Busy = 1'b0;
      end else if (UART_TX_VLD) begin
        if (w == 0) begin
          dly  = $urandom_range(dly_hi, dly_lo);
          hold = $urandom_range(hold_hi, hold_lo);
        end
        w++;
        if (w >= dly) begin
          UART_TX_Busy = 1'b1;
          rose = 1'b1;
          got_q.push_back(UART_TX_DATA);
          hold_left = hold;
          w = 0;
        end
      end else begin
        w = 0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic set_busy(input int dl, input int dh, input int hl, input int hh);
    dly_lo = dl; dly_hi = dh; hold_lo = hl; hold_hi = hh;
  endtask

  task automatic pulse(input logic rf, input logic alu, input logic [7:0] rd, input logic [15:0] ad);
    RF_RdData = rd; ALU_OUT = ad; RF_RdData_VLD = rf; ALU_OUT_VLD = alu;
    tick();
    RF_RdData_VLD = 1'b0; ALU_OUT_VLD = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(ARB_IDLE && !UART_TX_Busy) && n < 3000) begin tick(); n++; end
    chk({tag, "_idle_reached"}, (n < 3000), 1);
  endtask

  task automatic check_bytes(input string tag);
    logic [31:0] g;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? 32'(got_q[i]) : 'x;
      chk($sformatf("%s_byte%0d", tag, i), g, exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    tick(); tick();
    RST = 1'b1;
    tick();
    last_src = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n, vld_seen, mode;
    logic [7:0]  rd;
    logic [15:0] ad;
    RST = 1'b0; RF_RdData = '0; RF_RdData_VLD = 1'b0; ALU_OUT = '0; ALU_OUT_VLD = 1'b0;
    ERR_CLR = 1'b0; busy_auto = 1; last_src = 1'b1;
    set_busy(1, 4, 1, 5);
    tick(); tick();
    chk("rst_vld", UART_TX_VLD, 0);
    chk("rst_data", UART_TX_DATA, 0);
    chk("rst_idle", ARB_IDLE, 1);
    chk("rst_flags", {RF_OVF, ALU_OVF, TX_TIMEOUT}, 0);
    RST = 1'b1;
    tick();

    // Single RF byte and request latency
    set_busy(3, 3, 10, 10);
    pulse(1'b1, 1'b0, 8'hA5, 16'h0);
    push_rf(8'hA5);
    chk("lat_n1_vld", UART_TX_VLD, 0);
    chk("lat_n1_idle", ARB_IDLE, 0);
    tick();
    chk("lat_n2_vld", UART_TX_VLD, 1);
    chk("lat_n2_data", UART_TX_DATA, 8'hA5);
    wait_idle("rf_single");
    chk("rf_single_arb_idle", ARB_IDLE, 1);
    check_bytes("rf_single");

    // ALU split, low byte first
    set_busy(1, 4, 1, 5);
    pulse(1'b0, 1'b1, 8'h0, 16'h1234);
    push_alu(16'h1234);
    wait_idle("alu_split");
    check_bytes("alu_split");

    // Simultaneous sources and round-robin
    do_reset();
    pulse(1'b1, 1'b1, 8'h0F, 16'hBEEF);
    push_both(8'h0F, 16'hBEEF);
    wait_idle("both1");
    check_bytes("both1");
    pulse(1'b1, 1'b1, 8'hF0, 16'hCAFE);
    push_both(8'hF0, 16'hCAFE);
    wait_idle("both2");
    check_bytes("both2");
    pulse(1'b1, 1'b0, 8'h77, 16'h0);
    push_rf(8'h77);
    wait_idle("rf_then");
    pulse(1'b1, 1'b1, 8'h5C, 16'h1357);
    push_both(8'h5C, 16'h1357);
    wait_idle("both3");
    check_bytes("both3");

    // Overflow of the RF slot while an ALU message is draining
    set_busy(2, 2, 10, 10);
    pulse(1'b0, 1'b1, 8'h0, 16'hC3D4);
    push_alu(16'hC3D4);
    n = 0;
    while (!(UART_TX_Busy && !UART_TX_VLD) && n < 100) begin tick(); n++; end
    chk("ovf_drain_reached", (n < 100), 1);
    pulse(1'b1, 1'b0, 8'h11, 16'h0);
    pulse(1'b1, 1'b0, 8'h22, 16'h0);
    push_rf(8'h11);
    chk("ovf_rf_set", RF_OVF, 1);
    chk("ovf_alu_clear", ALU_OVF, 0);
    wait_idle("ovf");
    check_bytes("ovf");
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    chk("ovf_cleared", RF_OVF, 0);

    // Randomized messages
    set_busy(1, 4, 1, 5);
    for (int it = 0; it < 20; it++) begin
      mode = $urandom_range(2, 0);
      rd = 8'($urandom);
      ad = 16'($urandom);
      pulse(mode != 1, mode != 0, rd, ad);
      if (mode == 0)      push_rf(rd);
      else if (mode == 1) push_alu(ad);
      else                push_both(rd, ad);
      wait_idle($sformatf("rnd%0d", it));
      check_bytes($sformatf("rnd%0d", it));
    end
    chk("rnd_flags", {RF_OVF, ALU_OVF, TX_TIMEOUT}, 0);

    // Timeout with busy held low
    busy_auto = 0;
    tick();
    pulse(1'b1, 1'b0, 8'h5A, 16'h0);
    push_rf(8'h5A);
    tick();
    chk("to_vld_up", UART_TX_VLD, 1);
    repeat (254) tick();
    chk("to_before", TX_TIMEOUT, 0);
    chk("to_before_vld", UART_TX_VLD, 1);
    tick();
    chk("to_set", TX_TIMEOUT, 1);
    chk("to_set_vld", UART_TX_VLD, 1);
    set_busy(1, 1, 3, 3);
    busy_auto = 1;
    wait_idle("to");
    check_bytes("to");
    chk("to_sticky", TX_TIMEOUT, 1);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    chk("to_cleared", TX_TIMEOUT, 0);

    // Reset during the request of the second ALU byte
    set_busy(4, 4, 2, 2);
    pulse(1'b0, 1'b1, 8'h0, 16'h9ABC);
    n = 0;
    while (!(got_q.size() == 1 && UART_TX_VLD) && n < 200) begin tick(); n++; end
    chk("mid_req2_reached", (n < 200), 1);
    chk("mid_req2_data", UART_TX_DATA, 8'h9A);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_vld", UART_TX_VLD, 0);
    chk("mid_rst_data", UART_TX_DATA, 0);
    chk("mid_rst_idle", ARB_IDLE, 1);
    tick();
    RST = 1'b1;
    vld_seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (UART_TX_VLD) vld_seen++;
    end
    chk("mid_no_residual_vld", vld_seen, 0);
    chk("mid_idle_after", ARB_IDLE, 1);
    exp_q.push_back(8'hBC);
    check_bytes("mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
